hex_counter_ctrl: RTL and testbench

Button-driven sequencer for the 4-bit hex display counter. It synchronises and debounces two raw push-buttons (increment, decrement) on a free-running system clock and arbitrates between them. It steps a 4-bit count once per press, with optional hold-to-auto-repeat. `count` feeds the existing hex-to-7-segment decoder directly, so the buttons no longer act as the counter's clock.

---
 rtl/hex_counter_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hex_counter_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_counter_ctrl.sv
// Debounced two-button hex counter sequencer with conflict lock.
// Define HEX_CTRL_AUTOREPEAT_EN to build the hold-to-auto-repeat path.
module hex_counter_ctrl #(
  parameter int DB_CYCLES   = 250000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int RATE_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [3:0] count,
  output logic       step,
  output logic       wrap,
  output logic       locked
);

  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

`ifdef HEX_CTRL_AUTOREPEAT_EN
  localparam int TMR_MAX = (HOLD_CYCLES > RATE_CYCLES) ? HOLD_CYCLES : RATE_CYCLES;
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] RATE_LAST = TW'(RATE_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
`ifdef HEX_CTRL_AUTOREPEAT_EN
    S_REPEAT,
`endif
    S_LOCK
  } state_t;

  // Bit 0 = increment button, bit 1 = decrement button.
  logic [1:0] btn_raw;
  logic [1:0] db_level;

  assign btn_raw = {btn_dec, btn_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          meta_reg;
      logic          sync_reg;
      logic          level_reg;
      logic [DW-1:0] cnt_reg;

      // Level flips only after DB_CYCLES consecutive disagreeing cycles.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          meta_reg  <= 1'b0;
          sync_reg  <= 1'b0;
          level_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          meta_reg <= btn_raw[gi];
          sync_reg <= meta_reg;
          if (sync_reg != level_reg) begin
            if (cnt_reg == DB_LAST) begin
              level_reg <= sync_reg;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + DW'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign db_level[gi] = level_reg;
    end
  endgenerate

  state_t     state_reg, state_next;
  logic       dir_reg, dir_next;
  logic [3:0] count_reg, count_next;
  logic       step_reg, step_next;
  logic       wrap_reg, wrap_next;
  logic       do_step;
`ifdef HEX_CTRL_AUTOREPEAT_EN
  logic [TW-1:0] timer_reg, timer_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      dir_reg   <= 1'b0;
      count_reg <= 4'h0;
      step_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
`ifdef HEX_CTRL_AUTOREPEAT_EN
      timer_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      count_reg <= count_next;
      step_reg  <= step_next;
      wrap_reg  <= wrap_next;
`ifdef HEX_CTRL_AUTOREPEAT_EN
      timer_reg <= timer_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    count_next = count_reg;
    step_next  = 1'b0;
    wrap_next  = 1'b0;
    do_step    = 1'b0;
`ifdef HEX_CTRL_AUTOREPEAT_EN
    timer_next = timer_reg;
`endif
    case (state_reg)
      // IDLE is only entered with both levels low or the held one released,
      // so any high level seen here is a fresh press.
      S_IDLE: begin
        if (db_level == 2'b11) begin
          state_next = S_LOCK;
        end else if (db_level != 2'b00) begin
          do_step    = 1'b1;
          dir_next   = db_level[1];
          state_next = S_HELD;
`ifdef HEX_CTRL_AUTOREPEAT_EN
          timer_next = '0;
`endif
        end
      end
      S_HELD: begin
        if (!db_level[dir_reg]) begin
          state_next = S_IDLE;
        end else if (db_level[~dir_reg]) begin
          state_next = S_LOCK;
        end
`ifdef HEX_CTRL_AUTOREPEAT_EN
        else if (timer_reg == HOLD_LAST) begin
          do_step    = 1'b1;
          timer_next = '0;
          state_next = S_REPEAT;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
`endif
      end
`ifdef HEX_CTRL_AUTOREPEAT_EN
      S_REPEAT: begin
        if (!db_level[dir_reg]) begin
          state_next = S_IDLE;
        end else if (db_level[~dir_reg]) begin
          state_next = S_LOCK;
        end else if (timer_reg == RATE_LAST) begin
          do_step    = 1'b1;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
`endif
      S_LOCK: begin
        if (db_level == 2'b00) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (do_step) begin
      step_next = 1'b1;
      if (dir_next) begin
        count_next = count_reg - 4'd1;
        wrap_next  = (count_reg == 4'h0);
      end else begin
        count_next = count_reg + 4'd1;
        wrap_next  = (count_reg == 4'hF);
      end
    end
  end

  assign count  = count_reg;
  assign step   = step_reg;
  assign wrap   = wrap_reg;
  assign locked = (state_reg == S_LOCK);

endmodule

// File: tb/tb_hex_counter_ctrl.sv
// Directed bench for hex_counter_ctrl with DB=4, HOLD=20, RATE=8.
module tb_hex_counter_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_inc;
  logic       btn_dec;
  logic [3:0] count;
  logic       step;
  logic       wrap;
  logic       locked;

  int total = 0;
  int bad = 0;
  int step_cnt = 0;
  int wrap_cnt = 0;
  int lock_cnt = 0;
  logic [3:0] exp_count = 4'h0;

  hex_counter_ctrl #(
    .DB_CYCLES  (4),
    .HOLD_CYCLES(20),
    .RATE_CYCLES(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .count  (count),
    .step   (step),
    .wrap   (wrap),
    .locked (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step === 1'b1) step_cnt++;
    if (wrap === 1'b1) wrap_cnt++;
    if (locked === 1'b1) lock_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clean press held 10 cycles: step lands exactly 7 cycles after the press.
  task automatic press(input bit dec);
    logic [3:0] nxt;
    logic       wr;
    int         s0;
    s0  = step_cnt;
    nxt = dec ? exp_count - 4'd1 : exp_count + 4'd1;
    wr  = dec ? (exp_count == 4'h0) : (exp_count == 4'hF);
    if (dec) btn_dec = 1'b1;
    else btn_inc = 1'b1;
    tick(6);
    check("press_pre_step", {31'd0, step}, 32'd0);
    check("press_pre_count", {28'd0, count}, {28'd0, exp_count});
    tick(1);
    check("press_step", {31'd0, step}, 32'd1);
    check("press_count", {28'd0, count}, {28'd0, nxt});
    check("press_wrap", {31'd0, wrap}, {31'd0, wr});
    exp_count = nxt;
    tick(3);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick(10);
    check("press_one_step", step_cnt - s0, 32'd1);
    $display("press %s -> count=%h wrap=%0d", dec ? "dec" : "inc", count, wr);
  endtask

  initial begin
    int s0, w0, l0, rst_t, n_up;
    logic exp_s;
    logic [3:0] nxt;

    rst = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick(3);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    rst = 1'b1;

    s0 = step_cnt; w0 = wrap_cnt; l0 = lock_cnt;
    tick(50);
    check("idle_count", {28'd0, count}, 32'd0);
    check("idle_steps", step_cnt - s0, 32'd0);
    check("idle_wraps", wrap_cnt - w0, 32'd0);
    check("idle_locks", lock_cnt - l0, 32'd0);
    $display("idle 50 cycles -> count=%h", count);

    press(1'b0);

    // Bounce: 2-cycle segments 1,0,1,0,1,0 then stable high.
    s0 = step_cnt;
    for (int i = 0; i < 6; i++) begin
      btn_inc = (i % 2 == 0);
      tick(2);
    end
    btn_inc = 1'b1;
    tick(6);
    check("bounce_pre_count", {28'd0, count}, {28'd0, exp_count});
    tick(1);
    check("bounce_step", {31'd0, step}, 32'd1);
    check("bounce_count", {28'd0, count}, {28'd0, exp_count + 4'd1});
    exp_count = exp_count + 4'd1;
    tick(3);
    btn_inc = 1'b0;
    tick(10);
    check("bounce_one_step", step_cnt - s0, 32'd1);
    $display("bounced inc -> count=%h", count);

    while (exp_count != 4'hF) press(1'b0);
    press(1'b0);
    press(1'b1);

    while (exp_count != 4'h5) press(1'b1);

    // Hold dec; release raw at t=53 so the accepted level is low by t=60.
    s0 = step_cnt;
    btn_dec = 1'b1;
    tick(7);
    check("rep_first_step", {31'd0, step}, 32'd1);
    check("rep_first_count", {28'd0, count}, 32'd4);
    exp_count = 4'h4;
    for (int t = 1; t <= 70; t++) begin
      tick(1);
      exp_s = 1'b0;
`ifdef HEX_CTRL_AUTOREPEAT_EN
      if (t >= 20 && t <= 52 && ((t - 20) % 8) == 0) exp_s = 1'b1;
`endif
      if (exp_s) begin
        nxt = exp_count - 4'd1;
        check("rep_count", {28'd0, count}, {28'd0, nxt});
        check("rep_wrap", {31'd0, wrap}, {31'd0, exp_count == 4'h0});
        exp_count = nxt;
      end
      check("rep_step", {31'd0, step}, {31'd0, exp_s});
      if (t == 53) btn_dec = 1'b0;
    end
`ifdef HEX_CTRL_AUTOREPEAT_EN
    check("rep_total_steps", step_cnt - s0, 32'd6);
    check("rep_final_count", {28'd0, count}, 32'hF);
`else
    check("rep_total_steps", step_cnt - s0, 32'd1);
    check("rep_final_count", {28'd0, count}, 32'h4);
`endif
    $display("hold dec -> count=%h steps=%0d", count, step_cnt - s0);

    // Conflict: both pressed together, then release one, then the other.
    s0 = step_cnt;
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    tick(7);
    check("lock_set", {31'd0, locked}, 32'd1);
    check("lock_count", {28'd0, count}, {28'd0, exp_count});
    tick(5);
    btn_inc = 1'b0;
    tick(12);
    check("lock_one_released", {31'd0, locked}, 32'd1);
    btn_dec = 1'b0;
    tick(12);
    check("lock_cleared", {31'd0, locked}, 32'd0);
    check("lock_no_step", step_cnt - s0, 32'd0);
    check("lock_count_after", {28'd0, count}, {28'd0, exp_count});
    $display("conflict -> count=%h", count);

    // Reset while auto-repeating (mid-HELD without the repeat build).
    press(1'b0);
`ifdef HEX_CTRL_AUTOREPEAT_EN
    rst_t = 28;
    n_up  = 3;
`else
    rst_t = 0;
    n_up  = 1;
`endif
    btn_inc = 1'b1;
    tick(7 + rst_t);
    check("prerst_step", {31'd0, step}, 32'd1);
    check("prerst_count", {28'd0, count}, {28'd0, exp_count + 4'(n_up)});
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_count", {28'd0, count}, 32'd0);
    check("async_rst_step", {31'd0, step}, 32'd0);
    check("async_rst_wrap", {31'd0, wrap}, 32'd0);
    check("async_rst_locked", {31'd0, locked}, 32'd0);
    btn_inc = 1'b0;
    tick(3);
    rst = 1'b1;
    s0 = step_cnt;
    tick(20);
    check("postrst_count", {28'd0, count}, 32'd0);
    check("postrst_steps", step_cnt - s0, 32'd0);
    $display("reset mid-hold -> count=%h", count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
